// File: rtl/kbd_pkg.sv
// Shared constants for the key debounce / press-strobe block.
// Release strobes are enabled by defining KBD_RELEASE_EVENT_EN.
package kbd_pkg;

  localparam int unsigned KBD_DEBOUNCE_DEFAULT = 1_000_000;
  localparam int unsigned KBD_SYNC_STAGES      = 2;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous level input.
// The first stage is sync1 and the second is sync2; the output is sync2.
module sync_2ff
  import kbd_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic [KBD_SYNC_STAGES-1:0] sync_q;
  logic [KBD_SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[KBD_SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[KBD_SYNC_STAGES-1];

endmodule

// File: rtl/kbd_key_process.sv
// Debounces a raw key input and emits one registered strobe per accepted press.
// Define KBD_RELEASE_EVENT_EN to add the kbd_release strobe port.
module kbd_key_process
  import kbd_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = KBD_DEBOUNCE_DEFAULT,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rstn,
  input  logic kbd,
  output logic kbd_out
`ifdef KBD_RELEASE_EVENT_EN
  ,
  output logic kbd_release
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync2;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic             stable_q,     stable_d;
  logic             stable_dly_q, stable_dly_d;
  logic             kbd_out_q,    kbd_out_d;

  sync_2ff u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (kbd),
    .q    (sync2)
  );

  // Any cycle where sync2 matches the accepted level restarts the window.
  always_comb begin
    cnt_d        = cnt_q;
    stable_d     = stable_q;
    if (sync2 == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = sync2;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    stable_dly_d = stable_q;
    kbd_out_d    = stable_q & ~stable_dly_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q        <= '0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      kbd_out_q    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      kbd_out_q    <= kbd_out_d;
    end
  end

  assign kbd_out = kbd_out_q;

`ifdef KBD_RELEASE_EVENT_EN
  logic kbd_release_q, kbd_release_d;

  always_comb begin
    kbd_release_d = ~stable_q & stable_dly_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      kbd_release_q <= 1'b0;
    end else begin
      kbd_release_q <= kbd_release_d;
    end
  end

  assign kbd_release = kbd_release_q;
`endif

endmodule

// File: tb/tb_kbd_key_process.sv
// Self-checking bench for kbd_key_process with DEBOUNCE_CYCLES=8.
// Reference model: a key level is accepted once it has been seen at the synchronizer output for 8 consecutive cycles.
module tb_kbd_key_process;

  localparam int unsigned D = 8;

  logic clk;
  logic rstn;
  logic kbd;
  logic kbd_out;
`ifdef KBD_RELEASE_EVENT_EN
  logic kbd_release;
`endif

  int checks   = 0;
  int failures = 0;

  kbd_key_process #(.DEBOUNCE_CYCLES(D)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .kbd         (kbd),
    .kbd_out     (kbd_out)
`ifdef KBD_RELEASE_EVENT_EN
    ,
    .kbd_release (kbd_release)
`endif
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  // Reference model state
  logic m_s1, m_s2;
  logic m_win[$];
  logic m_stable;
  logic m_rise, m_fall;
  logic exp_out, exp_rel;

  function automatic void model_reset();
    m_s1 = 1'b0;
    m_s2 = 1'b0;
    m_win.delete();
    m_stable = 1'b0;
    m_rise = 1'b0;
    m_fall = 1'b0;
    exp_out = 1'b0;
    exp_rel = 1'b0;
  endfunction

  function automatic void model_step(input logic k);
    logic seen;
    logic all_diff;
    exp_out = m_rise;
    exp_rel = m_fall;
    seen = m_s2;
    m_s2 = m_s1;
    m_s1 = k;
    m_win.push_back(seen);
    if (m_win.size() > D) void'(m_win.pop_front());
    all_diff = (m_win.size() == D);
    foreach (m_win[i]) if (m_win[i] == m_stable) all_diff = 1'b0;
    m_rise = all_diff && !m_stable;
    m_fall = all_diff && m_stable;
    if (all_diff) begin
      m_stable = ~m_stable;
      m_win.delete();
    end
  endfunction

  task automatic tick(input logic k);
    @(negedge clk);
    kbd = k;
    @(posedge clk);
    model_step(k);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b1;
    kbd  = 1'b0;
    model_reset();
    #1 rstn = 1'b0;
    #2;
    checks++;
    if (kbd_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_out got=%b exp=0", kbd_out);
    end
    checks++;
    if ({dut.u_sync.sync_q, dut.stable_q, dut.stable_dly_q, dut.cnt_q} !== '0) begin
      failures++;
      $display("FAIL reset_regs got sync=%b stable=%b dly=%b cnt=%0d exp all 0",
               dut.u_sync.sync_q, dut.stable_q, dut.stable_dly_q, dut.cnt_q);
    end
    #2 rstn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0);
      checks++;
      if (kbd_out !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle cycle=%0d got=%b exp=0", i, kbd_out);
      end
    end
  endtask

  task automatic test_clean_press();
    int pulses = 0;
    int at = -1;
    for (int i = 0; i < 40; i++) begin
      tick(1'b1);
      checks++;
      if (kbd_out !== exp_out) begin
        failures++;
        $display("FAIL press_model cycle=%0d got=%b exp=%b", i, kbd_out, exp_out);
      end
      if (kbd_out === 1'b1) begin
        pulses++;
        if (at < 0) at = i;
      end
    end
    checks++;
    if (pulses !== 1) begin
      failures++;
      $display("FAIL press_count got=%0d exp=1", pulses);
    end
    checks++;
    if (at !== 10) begin
      failures++;
      $display("FAIL press_latency got=%0d exp=10", at);
    end
  endtask

  task automatic test_release();
    int rel_pulses = 0;
    int rel_at = -1;
    for (int i = 0; i < 40; i++) begin
      tick(1'b0);
      checks++;
      if (kbd_out !== 1'b0) begin
        failures++;
        $display("FAIL release_out cycle=%0d got=%b exp=0", i, kbd_out);
      end
`ifdef KBD_RELEASE_EVENT_EN
      checks++;
      if (kbd_release !== exp_rel) begin
        failures++;
        $display("FAIL release_model cycle=%0d got=%b exp=%b", i, kbd_release, exp_rel);
      end
      if (kbd_release === 1'b1) begin
        rel_pulses++;
        if (rel_at < 0) rel_at = i;
      end
`else
      if (exp_rel === 1'b1) begin
        rel_pulses++;
        if (rel_at < 0) rel_at = i;
      end
`endif
    end
    checks++;
    if (rel_pulses !== 1 || rel_at !== 10) begin
      failures++;
      $display("FAIL release_pulse got count=%0d at=%0d exp count=1 at=10", rel_pulses, rel_at);
    end
    checks++;
    if (dut.stable_q !== 1'b0) begin
      failures++;
      $display("FAIL release_level got=%b exp=0", dut.stable_q);
    end
  endtask

  task automatic test_bounce();
    int pulses = 0;
    int at = -1;
    for (int i = 0; i < 6; i++) begin
      tick(i < 5 ? 1'b1 : 1'b0);
      checks++;
      if (kbd_out !== 1'b0) begin
        failures++;
        $display("FAIL bounce_burst cycle=%0d got=%b exp=0", i, kbd_out);
      end
    end
    for (int i = 0; i < 40; i++) begin
      tick(1'b1);
      checks++;
      if (kbd_out !== exp_out) begin
        failures++;
        $display("FAIL bounce_model cycle=%0d got=%b exp=%b", i, kbd_out, exp_out);
      end
      if (kbd_out === 1'b1) begin
        pulses++;
        if (at < 0) at = i;
      end
    end
    checks++;
    if (pulses !== 1 || at !== 10) begin
      failures++;
      $display("FAIL bounce_pulse got count=%0d at=%0d exp count=1 at=10", pulses, at);
    end
    for (int i = 0; i < 30; i++) tick(1'b0);
  endtask

  task automatic test_glitch();
    int pulses = 0;
    for (int i = 0; i < 37; i++) begin
      tick(i < 7 ? 1'b1 : 1'b0);
      checks++;
      if (kbd_out !== exp_out) begin
        failures++;
        $display("FAIL glitch_model cycle=%0d got=%b exp=%b", i, kbd_out, exp_out);
      end
      if (kbd_out === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0 || dut.stable_q !== 1'b0) begin
      failures++;
      $display("FAIL glitch_reject got pulses=%0d stable=%b exp pulses=0 stable=0", pulses, dut.stable_q);
    end
  endtask

  task automatic test_mid_reset();
    int pulses = 0;
    int at = -1;
    for (int i = 0; i < 5; i++) begin
      tick(1'b1);
      checks++;
      if (kbd_out !== 1'b0) begin
        failures++;
        $display("FAIL midrst_pre cycle=%0d got=%b exp=0", i, kbd_out);
      end
    end
    #2 rstn = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({dut.u_sync.sync_q, dut.stable_q, dut.stable_dly_q, dut.cnt_q, kbd_out} !== '0) begin
      failures++;
      $display("FAIL midrst_regs got sync=%b stable=%b dly=%b cnt=%0d out=%b exp all 0",
               dut.u_sync.sync_q, dut.stable_q, dut.stable_dly_q, dut.cnt_q, kbd_out);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({dut.u_sync.sync_q, dut.cnt_q, kbd_out} !== '0) begin
      failures++;
      $display("FAIL midrst_hold got sync=%b cnt=%0d out=%b exp all 0",
               dut.u_sync.sync_q, dut.cnt_q, kbd_out);
    end
    #1 rstn = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick(1'b1);
      checks++;
      if (kbd_out !== exp_out) begin
        failures++;
        $display("FAIL midrst_model cycle=%0d got=%b exp=%b", i, kbd_out, exp_out);
      end
      if (kbd_out === 1'b1) begin
        pulses++;
        if (at < 0) at = i;
      end
    end
    checks++;
    if (pulses !== 1 || at !== 10) begin
      failures++;
      $display("FAIL midrst_pulse got count=%0d at=%0d exp count=1 at=10", pulses, at);
    end
  endtask

  task automatic test_random();
    logic lvl = 1'b0;
    int unsigned len;
    for (int b = 0; b < 40; b++) begin
      lvl = ~lvl;
      len = $urandom_range(12, 1);
      for (int unsigned i = 0; i < len; i++) begin
        tick(lvl);
        checks++;
        if (kbd_out !== exp_out) begin
          failures++;
          $display("FAIL random_out burst=%0d cycle=%0d got=%b exp=%b", b, i, kbd_out, exp_out);
        end
`ifdef KBD_RELEASE_EVENT_EN
        checks++;
        if (kbd_release !== exp_rel) begin
          failures++;
          $display("FAIL random_rel burst=%0d cycle=%0d got=%b exp=%b", b, i, kbd_release, exp_rel);
        end
`endif
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_glitch();
    test_mid_reset();
    for (int i = 0; i < 30; i++) tick(1'b0);
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
